// File: rtl/lsu.sv
// Load/store unit: takes the ALU effective address and rs2, runs one
// request/ready handshake with data memory, and returns formatted load data.
// Alignment and encoding faults are resolved in IDLE and never reach the bus.
//
// state | meaning
// IDLE  | no access in flight; decodes and registers a new request
// WAIT  | mem_req asserted, waiting for mem_ready or the timeout
// DONE  | one-cycle result: rdata_valid or err pulse, stall released
module lsu #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    input  logic             req_load,
    input  logic             req_store,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] addr,
    input  logic [WIDTH-1:0] wdata,
    output logic             stall,
    output logic [WIDTH-1:0] rdata,
    output logic             rdata_valid,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [3:0]       mem_be,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_MISALGN = 2'b01;
    localparam logic [1:0] CODE_ILLEGAL = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    // Counter value on the last WAIT cycle allowed before the bus error.
    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic [2:0]       f3_q, f3_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       code_q, code_d;
    logic [9:0]       cnt_q, cnt_d;

    logic             illegal, misaligned;
    logic [3:0]       be_dec;
    logic [WIDTH-1:0] wdata_dec;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [WIDTH-1:0] ld_fmt;

    // Request decode: fault classification, byte lanes and store-data replication.
    always_comb begin
        illegal = (req_load == req_store)
                || (req_load  && (funct3 == 3'b011 || funct3[2:1] == 2'b11))
                || (req_store && !(funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010));
        misaligned = (funct3[1:0] == 2'b01 && addr[0])
                   || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
        case (funct3[1:0])
            2'b00:   be_dec = 4'b0001 << addr[1:0];
            2'b01:   be_dec = addr[1] ? 4'b1100 : 4'b0011;
            default: be_dec = 4'b1111;
        endcase
        case (funct3[1:0])
            2'b00:   wdata_dec = {4{wdata[7:0]}};
            2'b01:   wdata_dec = {2{wdata[15:0]}};
            default: wdata_dec = wdata;
        endcase
    end

    // Load formatting from the registered offset and funct3.
    always_comb begin
        ld_byte = mem_rdata[8*off_q +: 8];
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_fmt = {24'd0, ld_byte};
            3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_fmt = {16'd0, ld_half};
            default: ld_fmt = mem_rdata;
        endcase
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        be_d        = be_q;
        we_d        = we_q;
        f3_d        = f3_q;
        off_d       = off_q;
        code_d      = code_q;
        cnt_d       = cnt_q;
        stall       = 1'b0;
        mem_req     = 1'b0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        err_code    = CODE_NONE;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    addr_d  = {addr[WIDTH-1:2], 2'b00};
                    wdata_d = wdata_dec;
                    be_d    = be_dec;
                    we_d    = req_store;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    cnt_d   = 10'd0;
                    if (illegal) begin
                        code_d  = CODE_ILLEGAL;
                        state_d = DONE;
                    end else if (misaligned) begin
                        code_d  = CODE_MISALGN;
                        state_d = DONE;
                    end else begin
                        code_d  = CODE_NONE;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    state_d = DONE;
                    if (!we_q) rdata_d = ld_fmt;
                end else if (cnt_q == CNT_LAST) begin
                    code_d  = CODE_TIMEOUT;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DONE: begin
                rdata_valid = (code_q == CODE_NONE) && !we_q;
                err         = (code_q != CODE_NONE);
                err_code    = code_q;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane controls are only meaningful while the request is on the bus.
    assign mem_we    = (state_q == WAIT) && we_q;
    assign mem_be    = (state_q == WAIT) ? be_q : 4'b0000;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

    // State register with synchronous reset; reset abandons any access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            be_q    <= 4'b0000;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            off_q   <= 2'b00;
            code_q  <= CODE_NONE;
            cnt_q   <= 10'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for lsu: the driver pushes expected bus requests, stall
// lengths and responses; a negedge monitor pops and compares them.
module tb_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_load = 1'b0, req_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0, wdata = '0;
    logic        stall, rdata_valid, err, mem_req, mem_we;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [1:0]  err_code;
    logic [3:0]  mem_be;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    lsu #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_load(req_load),
        .req_store(req_store), .funct3(funct3), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .err_code(err_code), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wd;
        logic        chk_wd;
        int          nreq;
    } mem_exp_t;

    typedef struct {
        logic        rv;
        logic        er;
        logic [1:0]  code;
        logic [31:0] rd;
    } resp_t;

    mem_exp_t    exp_mem[$];
    resp_t       exp_resp[$];
    int          exp_stall[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_stall"}, 32'(stall), 0);
        chk({tag, "_mem_req"}, 32'(mem_req), 0);
        chk({tag, "_mem_we"}, 32'(mem_we), 0);
        chk({tag, "_mem_be"}, 32'(mem_be), 0);
        chk({tag, "_rdata_valid"}, 32'(rdata_valid), 0);
        chk({tag, "_err"}, 32'(err), 0);
        chk({tag, "_err_code"}, 32'(err_code), 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    // Reference model: expectations from the RISC-V load/store rules, then drive.
    task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rw, input int lat);
        logic        ill, mis, done;
        logic [1:0]  sz, code;
        logic [3:0]  be;
        logic [31:0] wrep, v;
        int          k;
        mem_exp_t    me;
        resp_t       re;
        sz   = f3[1:0];
        ill  = (ld == st) || (ld && (f3 == 3 || f3 == 6 || f3 == 7)) || (st && f3 > 2);
        mis  = (sz == 1 && a[0]) || (sz == 2 && a % 4 != 0);
        be   = (sz == 0) ? 4'(1 << (a % 4)) : (sz == 1) ? ((a % 4 >= 2) ? 4'b1100 : 4'b0011) : 4'b1111;
        wrep = (sz == 0) ? (wd & 32'hFF) * 32'h01010101 :
               (sz == 1) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
        if (sz == 0) begin
            v = (rw >> (8 * (a % 4))) & 32'hFF;
            if (!f3[2] && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            v = (rw >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (!f3[2] && v >= 32768) v = v - 65536;
        end else begin
            v = rw;
        end
        code = ill ? 2'd2 : mis ? 2'd1 : (lat >= TO) ? 2'd3 : 2'd0;
        if (code == 1 || code == 2) begin
            exp_stall.push_back(1);
        end else begin
            me.a = a - (a % 4); me.be = be; me.we = st; me.wd = wrep; me.chk_wd = st;
            me.nreq = (code == 3) ? TO : lat + 1;
            exp_mem.push_back(me);
            exp_stall.push_back(me.nreq + 1);
        end
        if (code != 0) begin
            re.rv = 0; re.er = 1; re.code = code; re.rd = last_rd;
            exp_resp.push_back(re);
        end else if (ld) begin
            re.rv = 1; re.er = 0; re.code = 0; re.rd = v;
            exp_resp.push_back(re);
            last_rd = v;
        end
        req_valid = 1; req_load = ld; req_store = st; funct3 = f3; addr = a; wdata = wd;
        mem_ready = 0;
        k = 0;
        done = 0;
        for (int c = 0; c < 64; c++) begin
            @(posedge clk); #1;
            if (!stall) begin done = 1; break; end
            if (c == 0 && $urandom_range(0, 1) == 1) begin
                req_valid = 0; addr = $urandom; funct3 = 3'($urandom);
            end
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rw : $urandom;
            k++;
        end
        if (!done) chk("access_bound", 0, 1);
        req_valid = 0; mem_ready = 0;
        @(posedge clk); #1;
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            @(posedge clk); #1;
        end
        mem_ready = 0;
    endtask

    // Monitor: compares bus requests, stall lengths and responses as they appear.
    int       req_run = 0;
    int       stall_run = 0;
    logic     have_cur = 0;
    mem_exp_t cur;
    resp_t    r;
    always @(negedge clk) begin
        if (mem_req) begin
            if (req_run == 0) begin
                if (exp_mem.size() == 0) begin
                    chk("mem_req_unexpected", 1, 0);
                    have_cur = 0;
                end else begin
                    cur = exp_mem.pop_front();
                    have_cur = 1;
                end
            end
            if (have_cur) begin
                chk("mem_addr", mem_addr, cur.a);
                chk("mem_be", 32'(mem_be), 32'(cur.be));
                chk("mem_we", 32'(mem_we), 32'(cur.we));
                if (cur.chk_wd) chk("mem_wdata", mem_wdata, cur.wd);
            end
            req_run++;
        end else if (req_run != 0) begin
            if (have_cur) chk("mem_req_cycles", 32'(req_run), 32'(cur.nreq));
            req_run = 0;
        end
        if (stall) begin
            stall_run++;
        end else if (stall_run != 0) begin
            if (exp_stall.size() == 0) chk("stall_unexpected", 32'(stall_run), 0);
            else chk("stall_cycles", 32'(stall_run), 32'(exp_stall.pop_front()));
            stall_run = 0;
        end
        if (rdata_valid || err) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", {30'd0, rdata_valid, err}, 0);
            end else begin
                r = exp_resp.pop_front();
                chk("rdata_valid", 32'(rdata_valid), 32'(r.rv));
                chk("err", 32'(err), 32'(r.er));
                chk("err_code", 32'(err_code), 32'(r.code));
                chk("rdata", rdata, r.rd);
            end
        end
    end

    initial begin
        logic ld, st;
        logic [2:0]  f3;
        logic [31:0] a;
        int          lat, sel;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1;
        @(posedge clk); #1;

        access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0);
        access(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 0);
        access(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1);
        access(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 0, 0);
        access(1, 0, 3'b010, 32'h101, 0, 32'h12345678, 0);
        access(1, 0, 3'b011, 32'h100, 0, 32'h12345678, 0);
        access(1, 1, 3'b000, 32'h100, 0, 32'h12345678, 0);
        access(0, 1, 3'b100, 32'h100, 32'h55, 0, 0);
        access(1, 0, 3'b010, 32'h200, 0, 32'hCAFEF00D, 20);
        access(1, 0, 3'b101, 32'h202, 0, 32'h9876FEDC, TO - 1);
        access(1, 0, 3'b001, 32'h202, 0, 32'h9876FEDC, 2);
        gap(3);

        exp_mem.push_back('{a: 32'h300, be: 4'b1111, we: 1'b0, wd: 0, chk_wd: 1'b0, nreq: 1});
        exp_stall.push_back(2);
        req_valid = 1; req_load = 1; req_store = 0; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        req_valid = 0; rst_n = 0; mem_ready = 0;
        @(posedge clk); #1;
        rst_n = 1; mem_ready = 1; mem_rdata = 32'hA5A5A5A5;
        chk_zero("mid_reset");
        last_rd = 0;
        @(posedge clk); #1;
        mem_ready = 0;
        gap(2);

        for (int i = 0; i < 250; i++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0) begin ld = 1'($urandom_range(0, 1)); st = ld; end
            else if (sel <= 5) begin ld = 1; st = 0; end
            else begin ld = 0; st = 1; end
            f3 = 3'($urandom_range(0, 7));
            if (st && $urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 2));
            a = $urandom;
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            lat = ($urandom_range(0, 9) < 8) ? $urandom_range(0, TO - 1) : $urandom_range(TO, TO + 2);
            access(ld, st, f3, a, $urandom, $urandom, lat);
            if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
        end
        gap(4);
        chk("exp_mem_drained", 32'(exp_mem.size()), 0);
        chk("exp_resp_drained", 32'(exp_resp.size()), 0);
        chk("exp_stall_drained", 32'(exp_stall.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
